// File: rtl/fifo_drain_arbiter_if.sv
// Bundle of per-source FIFO read ports and the shared valid/ready output channel.
// The master modport is the arbiter side; slave is the FIFO/consumer side.
interface fifo_drain_arbiter_if #(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned WIDTH   = 16
);
  localparam int unsigned SrcW = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]       src_empty_i;
  logic [NUM_SRC*WIDTH-1:0] src_data_i;
  logic [NUM_SRC-1:0]       src_rd_en_o;
  logic                     m_valid_o;
  logic                     m_ready_i;
  logic [WIDTH-1:0]         m_data_o;
  logic [SrcW-1:0]          m_src_o;

  modport master (
    input  src_empty_i,
    input  src_data_i,
    output src_rd_en_o,
    output m_valid_o,
    input  m_ready_i,
    output m_data_o,
    output m_src_o
  );

  modport slave (
    output src_empty_i,
    output src_data_i,
    input  src_rd_en_o,
    input  m_valid_o,
    output m_ready_i,
    input  m_data_o,
    input  m_src_o
  );
endinterface

// File: rtl/fifo_drain_arbiter.sv
// Round-robin burst drain scheduler: pulls words from NUM_SRC FIFOs into one
// registered valid/ready output, staying on a source for up to BURST words.
module fifo_drain_arbiter #(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned BURST   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_n,
  input  logic                 enable_i,
  fifo_drain_arbiter_if.master drain_io
);
  localparam int unsigned SrcW = $clog2(NUM_SRC);
  localparam int unsigned CntW = $clog2(BURST + 1);
  localparam logic [CntW-1:0] BurstMax = CntW'(BURST);
  localparam logic [SrcW-1:0] LastSrc  = SrcW'(NUM_SRC - 1);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e           state_q, state_d;
  logic [SrcW-1:0]  cur_q, cur_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             m_valid_q;
  logic [WIDTH-1:0] m_data_q;
  logic [SrcW-1:0]  m_src_q;

  logic             can_load;
  logic             do_read;
  logic [SrcW-1:0]  sel;
  logic             rot_found;
  logic [SrcW-1:0]  rot_idx;
  logic [WIDTH-1:0] src_word [NUM_SRC];

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
    assign src_word[g] = drain_io.src_data_i[g*WIDTH +: WIDTH];
  end

  // First non-empty source after cur, wrapping, with cur itself checked last.
  always_comb begin
    int unsigned     cand;
    logic [SrcW-1:0] cand_idx;
    rot_found = 1'b0;
    rot_idx   = cur_q;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      cand     = (32'(cur_q) + k) % NUM_SRC;
      cand_idx = SrcW'(cand);
      if (!rot_found && !drain_io.src_empty_i[cand_idx]) begin
        rot_found = 1'b1;
        rot_idx   = cand_idx;
      end
    end
  end

  assign can_load = enable_i && (!m_valid_q || drain_io.m_ready_i);

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    sel     = cur_q;
    do_read = 1'b0;
    if (!enable_i) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else if (can_load) begin
      if (state_q == StBurst && !drain_io.src_empty_i[cur_q] && cnt_q < BurstMax) begin
        do_read = rst_n;
        cnt_d   = cnt_q + CntW'(1);
      end else if (rot_found) begin
        do_read = rst_n;
        sel     = rot_idx;
        cur_d   = rot_idx;
        cnt_d   = CntW'(1);
        state_d = StBurst;
      end else begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    end
  end

  always_comb begin
    drain_io.src_rd_en_o      = '0;
    drain_io.src_rd_en_o[sel] = do_read;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cur_q     <= LastSrc;
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_src_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      if (do_read) begin
        m_valid_q <= 1'b1;
        m_data_q  <= src_word[sel];
        m_src_q   <= sel;
      end else if (drain_io.m_ready_i) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  assign drain_io.m_valid_o = m_valid_q;
  assign drain_io.m_data_o  = m_data_q;
  assign drain_io.m_src_o   = m_src_q;
endmodule

// File: doc/fifo_drain_arbiter.md
# fifo_drain_arbiter

Round-robin drain scheduler that shares one downstream consumer between NUM_SRC source FIFOs. It watches each FIFO's empty flag, pulses that FIFO's read enable, and captures the returned word into a single output register with a valid/ready handshake. Sources are served in bursts of up to BURST words before the grant rotates. The block sits between the per-channel input FIFOs of the accelerator and the shared compute datapath.

## Interface
- NUM_SRC, 2: number of source FIFOs; must be ≥2 (need not be a power of two).
- WIDTH, 16: data word width.
- BURST, 4: maximum consecutive words taken from one source per grant; must be ≥1 (1 = pure round robin).
- clk_i  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- enable_i  in  1  permits new fetches; the output register keeps draining when low.
- src_empty_i  in  NUM_SRC  per-source FIFO empty flag.
- src_data_i  in  NUM_SRC*WIDTH  per-source FIFO read data; source i occupies bits [i*WIDTH +: WIDTH]. The word is valid combinationally in the same cycle its rd_en is high.
- src_rd_en_o  out  NUM_SRC  per-source read enable; at most one bit high per cycle.
- m_valid_o  out  1  output word valid.
- m_ready_i  in  1  consumer accepts the word.
- m_data_o  out  WIDTH  output word.
- m_src_o  out  $clog2(NUM_SRC)  index of the source that supplied m_data_o.

## Operation
- State: IDLE or BURST; registers cur (grant index), burst_cnt (0..BURST), and the output register (m_valid_o, m_data_o, m_src_o).
- Fetch slot: can_load = enable_i && (!m_valid_o || m_ready_i).
- In a fetch slot, decide combinationally:
  - Continue: if state = BURST, !src_empty_i[cur] and burst_cnt < BURST, read cur and increment burst_cnt.
  - Rotate: otherwise, search sources cur+1, cur+2, … with modulo-NUM_SRC wrap, including cur itself last. The first non-empty source found becomes cur; set burst_cnt = 1 and state = BURST.
  - Idle: if every source is empty, issue no read and set state = IDLE and burst_cnt = 0. cur is unchanged.
- On a read: assert src_rd_en_o[sel] for that cycle only. At the clock edge, capture src_data_i[sel], set m_src_o = sel and m_valid_o = 1.
- In a non-fetch cycle:
  - If m_valid_o && m_ready_i, clear m_valid_o.
  - m_data_o and m_src_o hold.
- enable_i low: no read. State goes to IDLE and burst_cnt to 0; cur is kept. A pending output word remains until accepted.
- src_rd_en_o is never asserted when the selected src_empty_i is high and never when can_load is low.
- Word ordering within one source is preserved; no word is dropped or duplicated.

## Timing
- Reset values:
  - m_valid_o = 0, m_data_o = 0, m_src_o = 0, src_rd_en_o = 0.
  - state = IDLE, burst_cnt = 0, cur = NUM_SRC-1, so the first grant goes to source 0.
- src_rd_en_o is combinational from registered state, src_empty_i, enable_i, m_valid_o and m_ready_i.
- Latency: a source becoming non-empty in cycle N (with can_load true) is read in cycle N; m_valid_o rises at edge N+1.
- Throughput: one word per cycle while m_ready_i is held high and data is available, including across grant rotation (no bubble on rotate).
- Backpressure:
  - While m_valid_o && !m_ready_i, m_data_o and m_src_o are stable and no read is issued.
  - Accept and refill in the same cycle is required.
- Simultaneous events:
  - When a source empties mid-burst, rotation happens in the same cycle.
  - A source that refills after rotation waits its turn.
- Reset mid-operation: the output word is discarded. The source FIFOs share rst_n, so the system restarts clean.

## Test plan
- Single source: NUM_SRC=2, BURST=4, src0 holds A0..A5, src1 empty, m_ready_i=1 -> m_data_o = A0..A5 on 6 consecutive cycles, m_src_o=0, one rd_en per word.
- Burst rotation: both sources hold 6 words, BURST=4, m_ready_i=1 -> order A0..A3, B0..B3, A4, A5, B4, B5 with no idle cycles.
- Backpressure: src0 holds 3 words, m_ready_i low for 5 cycles after the first valid -> m_data_o=A0 held stable, src_rd_en_o=0 throughout; after release, A1 and A2 follow back-to-back.
- Empty/refill: src0 holds 2 words (BURST=4), src1 holds 2 words; src0 refills while src1 is being served -> A0, A1, B0, B1, then new src0 words; no rd_en is issued to an empty source.
- Enable gating: drop enable_i for 3 cycles mid-burst with a word pending -> the pending word is still accepted, no reads occur, and the burst restarts with burst_cnt=1 at the next rotation from cur.
- Reset mid-burst: assert rst_n low for 1 cycle while m_valid_o=1 -> next cycle m_valid_o=0 and src_rd_en_o=0; the first post-reset grant goes to source 0.
